// File: rtl/led_pkg.sv
// Shared definitions for the LED mode controller: mode encoding, the
// 50 MHz-derived timing defaults and the mode sequencing helper.
package led_pkg;

    // Display modes, in the order a key press steps through them.
    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_BLINK = 2'd1,
        MODE_RUN   = 2'd2,
        MODE_ON    = 2'd3
    } mode_t;

    // 0.5 s pattern step at 50 MHz.
    localparam int DEFAULT_TICK_CYCLES     = 25_000_000;
    // 20 ms debounce window at 50 MHz.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
    // Flops between the raw key pin and the debouncer.
    localparam int SYNC_STAGES             = 2;

    // Mode that follows cur on an accepted press (OFF -> BLINK -> RUN -> ON -> OFF).
    function automatic mode_t next_mode(input mode_t cur);
        mode_t nxt;
        case (cur)
            MODE_OFF:   nxt = MODE_BLINK;
            MODE_BLINK: nxt = MODE_RUN;
            MODE_RUN:   nxt = MODE_ON;
            default:    nxt = MODE_OFF;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Key conditioning: brings the asynchronous push button into the clock
// domain, filters contact bounce and emits a single-cycle pulse for each
// accepted press (released-to-pressed transition only).
module key_debounce
    import led_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_in,
    output logic key_press
);

    // The counter only has to reach DEBOUNCE_CYCLES-1 before it clears.
    localparam int                CNT_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sync_key;
    logic                   level_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   press_reg;
    logic                   accept;

    assign sync_key = sync_reg[SYNC_STAGES-1];

    // The change is accepted on the cycle the counter has already seen
    // DEBOUNCE_CYCLES-1 differing samples and the current one still differs.
    assign accept = (sync_key != level_reg) && (cnt_reg == CNT_LAST);

    // Shift the raw key through the synchronizer; idle level is released (1).
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], key_in};
        end
    end

    // Count consecutive samples that disagree with the debounced level and
    // adopt the new level once the disagreement has lasted long enough.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            level_reg <= 1'b1;
            cnt_reg   <= '0;
        end else if (sync_key == level_reg) begin
            cnt_reg   <= '0;
        end else if (accept) begin
            level_reg <= sync_key;
            cnt_reg   <= '0;
        end else begin
            cnt_reg   <= cnt_reg + CNT_W'(1);
        end
    end

    // Pulse on the same edge the debounced level falls; releases are ignored.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            press_reg <= 1'b0;
        end else begin
            press_reg <= accept && level_reg && !sync_key;
        end
    end

    assign key_press = press_reg;

endmodule

// File: rtl/led_mode_ctrl.sv
// Push-button LED demo driver: each debounced press steps the display mode
// (OFF, BLINK, RUN, ON) and an internal pacing tick animates the pattern.
module led_mode_ctrl
    import led_pkg::*;
#(
    parameter int LED_NUM         = 4,
    parameter int TICK_CYCLES     = DEFAULT_TICK_CYCLES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               key_in,
    output logic [LED_NUM-1:0] led_out,
    output logic [1:0]         mode
);

    localparam int                TICK_W    = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

    logic               key_press;
    logic [TICK_W-1:0]  tick_cnt_reg;
    logic               tick;
    mode_t              mode_reg;
    mode_t              mode_next;
    logic [LED_NUM-1:0] led_reg;
    logic [LED_NUM-1:0] entry_pattern;
    logic [LED_NUM-1:0] step_pattern;
    logic [LED_NUM-1:0] rot_next;

    genvar gi;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_in    (key_in),
        .key_press (key_press)
    );

    assign tick = (tick_cnt_reg == TICK_LAST);

    // Free-running pacing counter; a press restarts it so the new mode gets
    // a full step interval before its first animation step.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tick_cnt_reg <= '0;
        end else if (key_press || tick) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + TICK_W'(1);
        end
    end

    // Running-light rotate left: bit LED_NUM-1 wraps around into bit 0.
    generate
        for (gi = 0; gi < LED_NUM; gi++) begin : g_rot
            assign rot_next[gi] = led_reg[(gi + LED_NUM - 1) % LED_NUM];
        end
    endgenerate

    // Mode that a press would select and the LED image it starts with.
    always_comb begin
        mode_next     = next_mode(mode_reg);
        entry_pattern = '1;
        case (mode_next)
            MODE_OFF:   entry_pattern = '0;
            MODE_RUN:   entry_pattern = LED_NUM'(1);
            default:    entry_pattern = '1;
        endcase
    end

    // LED image after one animation step in the current mode.
    always_comb begin
        step_pattern = led_reg;
        case (mode_reg)
            MODE_BLINK: step_pattern = ~led_reg;
            MODE_RUN:   step_pattern = rot_next;
            default:    step_pattern = led_reg;
        endcase
    end

    // Mode state machine with registered LED drive; a press always takes
    // priority over a coincident tick.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mode_reg <= MODE_BLINK;
            led_reg  <= '1;
        end else if (key_press) begin
            mode_reg <= mode_next;
            led_reg  <= entry_pattern;
        end else if (tick) begin
            led_reg  <= step_pattern;
        end
    end

    assign led_out = led_reg;
    assign mode    = mode_reg;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Scoreboard bench for led_mode_ctrl with small timing parameters. A
// reference model, working from key sample history and elapsed-time
// arithmetic, queues the expected mode/LED image after every clock edge; a
// separate monitor pops and compares on the falling edge.
module tb_led_mode_ctrl;

    localparam int LED_NUM = 4;
    localparam int T       = 8;
    localparam int D       = 4;

    typedef struct packed {
        logic [1:0]         mode;
        logic [LED_NUM-1:0] led;
    } exp_t;

    logic               sys_clk;
    logic               sys_rst_n;
    logic               key_in;
    logic [LED_NUM-1:0] led_out;
    logic [1:0]         mode;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    led_mode_ctrl #(
        .LED_NUM         (LED_NUM),
        .TICK_CYCLES     (T),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_in    (key_in),
        .led_out   (led_out),
        .mode      (mode)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    function automatic void check(input string name, input logic [1:0] exp_mode,
                                  input logic [LED_NUM-1:0] exp_led);
        checks++;
        if (mode !== exp_mode || led_out !== exp_led) begin
            failures++;
            $display("FAIL %s t=%0t: got mode=%0d led=%b, expected mode=%0d led=%b",
                     name, $time, mode, led_out, exp_mode, exp_led);
        end else begin
            $display("ok   %s t=%0t: mode=%0d led=%b", name, $time, mode, led_out);
        end
    endfunction

    // LED image for a mode, given how many whole step intervals have elapsed
    // since the mode was entered.
    function automatic logic [LED_NUM-1:0] pattern(input logic [1:0] md, input int steps);
        logic [LED_NUM-1:0] p;
        case (md)
            2'd0:    p = '0;
            2'd1:    p = (steps % 2 == 0) ? '1 : '0;
            2'd2:    p = LED_NUM'(1 << (steps % LED_NUM));
            default: p = '1;
        endcase
        return p;
    endfunction

    // Reference model. Edges are numbered from 1 after reset release; the
    // debounced level flips at edge n when the key samples taken at edges
    // n-D-1 .. n-2 all disagree with it (samples before reset count as high).
    initial begin : model
        int         n;
        int         restart;
        bit         deb;
        bit         pend;
        bit         all_diff;
        bit         s;
        bit         hist[$];
        logic [1:0] m_mode;
        n = 0; restart = 0; deb = 1'b1; pend = 1'b0; m_mode = 2'd1;
        forever begin
            @(posedge sys_clk or negedge sys_rst_n);
            if (!sys_rst_n) begin
                n = 0; restart = 0; deb = 1'b1; pend = 1'b0; m_mode = 2'd1;
                hist.delete();
                hist.push_back(1'b1);
                hist.push_back(1'b1);
                exp_q.delete();
            end else begin
                n++;
                hist.push_back(key_in);
                if (pend) begin
                    m_mode  = m_mode + 2'd1;
                    restart = n;
                    pend    = 1'b0;
                end
                all_diff = 1'b1;
                for (int k = n - D; k <= n - 1; k++) begin
                    s = (k < 0) ? 1'b1 : hist[k];
                    if (s == deb) all_diff = 1'b0;
                end
                if (all_diff) begin
                    deb = ~deb;
                    if (!deb) pend = 1'b1;
                end
                exp_q.push_back(exp_t'({m_mode, pattern(m_mode, (n - restart) / T)}));
            end
        end
    end

    // Monitor: compare DUT outputs on the falling edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge sys_clk);
            if (!sys_rst_n) begin
                check("reset_hold", 2'd1, '1);
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("scoreboard", e.mode, e.led);
            end
        end
    end

    task automatic key_for(input logic val, input int cycles);
        key_in = val;
        repeat (cycles) @(negedge sys_clk);
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        #1 sys_rst_n = 1'b0;
        #1 check("async_reset", 2'd1, '1);
        repeat (2) @(negedge sys_clk);
        #1 sys_rst_n = 1'b1;
    endtask

    initial begin : stimulus
        logic val;
        sys_rst_n = 1'b1;
        key_in    = 1'b1;
        #2 sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        #1 sys_rst_n = 1'b1;

        // Idle: blink pattern from reset.
        key_for(1'b1, 20);
        // Long hold: exactly one press into RUN, then several rotations.
        key_for(1'b0, 20);
        key_for(1'b1, 40);
        // Short glitches of 1, 2 and 3 cycles: no press.
        for (int g = 1; g <= 3; g++) begin
            key_for(1'b0, g);
            key_for(1'b1, 8);
        end
        // Four clean presses through the whole mode ring.
        for (int p = 0; p < 4; p++) begin
            key_for(1'b0, 8);
            key_for(1'b1, 22);
        end
        // Press landing on the same edge as a BLINK tick.
        do_reset();
        key_for(1'b1, 1);
        key_for(1'b0, 10);
        key_for(1'b1, 30);
        // Reset mid-debounce while in RUN, key held low across reset.
        key_for(1'b0, 3);
        do_reset();
        key_for(1'b0, 12);
        key_for(1'b1, 30);
        // Randomized key activity with bounce-like run lengths.
        val = 1'b0;
        for (int r = 0; r < 60; r++) begin
            key_for(val, int'($urandom_range(1, 12)));
            val = ~val;
        end
        key_for(1'b1, 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
